dram_arbiter: RTL and testbench

DRAM_ARBITER -- requirements
Module: dram_arbiter

---
 rtl/ram8mb_pkg.sv | 19 +
 rtl/dram_arbiter_rfsh_timer.sv | 44 ++++
 rtl/dram_arbiter.sv | 132 +++++++++++++
 tb/tb_dram_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram8mb_pkg.sv
// Shared types and default timing for the DRAM arbiter: FSM state encoding
// and refresh interval / pending ceiling / refresh RAS width defaults.
package ram8mb_pkg;

    localparam int RFSH_PERIOD_DEF  = 110;
    localparam int MAX_PENDING_DEF  = 4;
    localparam int RFSH_RAS_CYC_DEF = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACC_RAS = 3'd1,
        ACC_CAS = 3'd2,
        ACC_PRE = 3'd3,
        RF_CAS  = 3'd4,
        RF_RAS  = 3'd5,
        RF_PRE  = 3'd6
    } state_t;

endpackage

// File: rtl/dram_arbiter_rfsh_timer.sv
// Refresh bookkeeping: free-running interval counter, saturating count of
// owed refreshes, and the sticky flag for ticks that could not be recorded.
module rfsh_timer
    import ram8mb_pkg::*;
#(
    parameter int RFSH_PERIOD = RFSH_PERIOD_DEF,
    parameter int MAX_PENDING = MAX_PENDING_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rfsh_done,
    output logic [2:0] pending,
    output logic       lost
);

    localparam int CW = (RFSH_PERIOD > 1) ? $clog2(RFSH_PERIOD) : 1;

    logic [CW-1:0] interval;
    logic          tick;

    assign tick = (interval == CW'(RFSH_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            interval <= '0;
            pending  <= '0;
            lost     <= 1'b0;
        end else begin
            interval <= tick ? '0 : interval + 1'b1;
            // A tick and a completed refresh in the same cycle cancel out.
            unique case ({tick, rfsh_done})
                2'b10: begin
                    if (pending == 3'(MAX_PENDING)) lost <= 1'b1;
                    else                            pending <= pending + 1'b1;
                end
                2'b01: begin
                    if (pending != 3'd0) pending <= pending - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// DRAM access/refresh arbiter with CAS-before-RAS refresh and registered strobes.
// Optional macro RFSH_BANK_ROTATE_EN adds the rfsh_bank rotation output.
module dram_arbiter
    import ram8mb_pkg::*;
#(
    parameter int RFSH_PERIOD  = RFSH_PERIOD_DEF,
    parameter int MAX_PENDING  = MAX_PENDING_DEF,
    parameter int RFSH_RAS_CYC = RFSH_RAS_CYC_DEF
) (
    input  logic       cpu_clk,
    input  logic       cpu_rst,
    input  logic       acc_req,
    input  logic       acc_wr,
    input  logic       acc_lds,
    input  logic       acc_uds,
    output logic       acc_ack,
    output logic       dram_nras,
    output logic       dram_nlcas,
    output logic       dram_nucas,
    output logic       dram_wrn,
    output logic       mux_col,
    output logic       rfsh_busy,
    output logic [2:0] rfsh_pending,
    output logic       rfsh_lost,
`ifdef RFSH_BANK_ROTATE_EN
    output logic [1:0] rfsh_bank,
`endif
    output state_t     fsm_state
);

    // Handshake: acc_req is a level the CPU holds until it has seen acc_ack and
    // ended its bus cycle; acc_ack stays high while acc_req holds and falls
    // on the precharge cycle that follows acc_req dropping.

    localparam int RC_W = (RFSH_RAS_CYC > 1) ? $clog2(RFSH_RAS_CYC) : 1;

    state_t          state;
    logic [RC_W-1:0] ras_cnt;
    logic            rfsh_done;
    logic            start_rfsh;

    assign fsm_state  = state;
    assign rfsh_done  = (state == RF_PRE);
    // A full backlog outranks the CPU; otherwise refresh only fills idle time.
    assign start_rfsh = (rfsh_pending == 3'(MAX_PENDING)) ||
                        (!acc_req && rfsh_pending != 3'd0);

    rfsh_timer #(
        .RFSH_PERIOD (RFSH_PERIOD),
        .MAX_PENDING (MAX_PENDING)
    ) u_rfsh_timer (
        .clk       (cpu_clk),
        .rst       (cpu_rst),
        .rfsh_done (rfsh_done),
        .pending   (rfsh_pending),
        .lost      (rfsh_lost)
    );

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state      <= IDLE;
            dram_nras  <= 1'b1;
            dram_nlcas <= 1'b1;
            dram_nucas <= 1'b1;
            dram_wrn   <= 1'b1;
            mux_col    <= 1'b0;
            acc_ack    <= 1'b0;
            rfsh_busy  <= 1'b0;
            ras_cnt    <= '0;
`ifdef RFSH_BANK_ROTATE_EN
            rfsh_bank  <= 2'd0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_rfsh) begin
                        state      <= RF_CAS;
                        dram_nlcas <= 1'b0;
                        dram_nucas <= 1'b0;
                        rfsh_busy  <= 1'b1;
                    end else if (acc_req) begin
                        state     <= ACC_RAS;
                        dram_nras <= 1'b0;
                    end
                end
                ACC_RAS, ACC_CAS: begin
                    if (acc_req) begin
                        state      <= ACC_CAS;
                        mux_col    <= 1'b1;
                        dram_nlcas <= ~acc_lds;
                        dram_nucas <= ~acc_uds;
                        dram_wrn   <= ~acc_wr;
                        acc_ack    <= 1'b1;
                    end else begin
                        state      <= ACC_PRE;
                        dram_nras  <= 1'b1;
                        dram_nlcas <= 1'b1;
                        dram_nucas <= 1'b1;
                        dram_wrn   <= 1'b1;
                        mux_col    <= 1'b0;
                        acc_ack    <= 1'b0;
                    end
                end
                ACC_PRE: state <= IDLE;
                RF_CAS: begin
                    state     <= RF_RAS;
                    dram_nras <= 1'b0;
                    ras_cnt   <= RC_W'(RFSH_RAS_CYC - 1);
                end
                RF_RAS: begin
                    if (ras_cnt == '0) begin
                        state      <= RF_PRE;
                        dram_nras  <= 1'b1;
                        dram_nlcas <= 1'b1;
                        dram_nucas <= 1'b1;
                    end else begin
                        ras_cnt <= ras_cnt - 1'b1;
                    end
                end
                RF_PRE: begin
                    state     <= IDLE;
                    rfsh_busy <= 1'b0;
`ifdef RFSH_BANK_ROTATE_EN
                    rfsh_bank <= rfsh_bank + 2'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed scoreboard bench for dram_arbiter: the stimulus thread queues the
// expected output snapshot per cycle, a monitor compares on the falling edge.
module tb_dram_arbiter;
    import ram8mb_pkg::*;

    localparam int W = 14;

    // Strobe patterns: {nras, nlcas, nucas, wrn, mux_col, acc_ack, rfsh_busy}
    localparam logic [6:0] S_IDLE = 7'b1111000;
    localparam logic [6:0] S_RAS  = 7'b0111000;
    localparam logic [6:0] S_RCAS = 7'b1001001;
    localparam logic [6:0] S_RRAS = 7'b0001001;
    localparam logic [6:0] S_RPRE = 7'b1111001;

    logic       clk = 1'b0;
    logic       rst, acc_req, acc_wr, acc_lds, acc_uds;
    logic       acc_ack, dram_nras, dram_nlcas, dram_nucas, dram_wrn;
    logic       mux_col, rfsh_busy, rfsh_lost;
    logic [2:0] rfsh_pending;
    state_t     fsm_state;
`ifdef RFSH_BANK_ROTATE_EN
    logic [1:0] rfsh_bank;
`endif

    // clock / reset
    always #5 clk = ~clk;

    dram_arbiter #(
        .RFSH_PERIOD  (110),
        .MAX_PENDING  (4),
        .RFSH_RAS_CYC (2)
    ) dut (
        .cpu_clk      (clk),
        .cpu_rst      (rst),
        .acc_req      (acc_req),
        .acc_wr       (acc_wr),
        .acc_lds      (acc_lds),
        .acc_uds      (acc_uds),
        .acc_ack      (acc_ack),
        .dram_nras    (dram_nras),
        .dram_nlcas   (dram_nlcas),
        .dram_nucas   (dram_nucas),
        .dram_wrn     (dram_wrn),
        .mux_col      (mux_col),
        .rfsh_busy    (rfsh_busy),
        .rfsh_pending (rfsh_pending),
        .rfsh_lost    (rfsh_lost),
`ifdef RFSH_BANK_ROTATE_EN
        .rfsh_bank    (rfsh_bank),
`endif
        .fsm_state    (fsm_state)
    );

    logic [W-1:0] obs;
    assign obs = {fsm_state, dram_nras, dram_nlcas, dram_nucas, dram_wrn,
                  mux_col, acc_ack, rfsh_busy, rfsh_pending, rfsh_lost};

    // scoreboard
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           tests = 0;
    int           fails = 0;
    int           cyc   = 0;
    logic [W-1:0] mon_exp;
    string        mon_name;

    function automatic logic [W-1:0] ev(input state_t s, input logic [6:0] sig,
                                        input logic [2:0] p, input logic l);
        return {s, sig, p, l};
    endfunction

    function automatic logic [6:0] cas(input logic lc, input logic uc, input logic w);
        return {1'b0, lc, uc, w, 3'b110};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            tests++;
            if (obs !== mon_exp) begin
                fails++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", mon_name, cyc, obs, mon_exp);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic chk(input string n, input logic [W-1:0] e);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic do_rfsh(input logic [2:0] p, input logic l);
        step(); chk("rf_cas", ev(RF_CAS, S_RCAS, p, l));
        step(); chk("rf_ras1", ev(RF_RAS, S_RRAS, p, l));
        step(); chk("rf_ras2", ev(RF_RAS, S_RRAS, p, l));
        step(); chk("rf_pre", ev(RF_PRE, S_RPRE, p, l));
        step(); chk("rf_idle", ev(IDLE, S_IDLE, p - 3'd1, l));
    endtask

    task automatic set_acc(input logic r, input logic w, input logic l, input logic u);
        acc_req = r; acc_wr = w; acc_lds = l; acc_uds = u;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d expected end by cycle 1230", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_acc(1'b0, 1'b0, 1'b0, 1'b0);
        step(); step();
        cyc = 0;
        chk("reset", ev(IDLE, S_IDLE, 3'd0, 1'b0));
        rst = 1'b0;

        // word read, req held six cycles
        set_acc(1'b1, 1'b0, 1'b1, 1'b1);
        step(); chk("rd_ras", ev(ACC_RAS, S_RAS, 3'd0, 1'b0));
        repeat (5) begin step(); chk("rd_cas", ev(ACC_CAS, cas(1'b0, 1'b0, 1'b1), 3'd0, 1'b0)); end
        acc_req = 1'b0;
        step(); chk("rd_pre", ev(ACC_PRE, S_IDLE, 3'd0, 1'b0));
        step(); chk("rd_idle", ev(IDLE, S_IDLE, 3'd0, 1'b0));

        // upper-byte write
        set_acc(1'b1, 1'b1, 1'b0, 1'b1);
        step(); chk("wr_ras", ev(ACC_RAS, S_RAS, 3'd0, 1'b0));
        repeat (2) begin step(); chk("wr_cas", ev(ACC_CAS, cas(1'b1, 1'b0, 1'b0), 3'd0, 1'b0)); end
        acc_req = 1'b0;
        step(); chk("wr_pre", ev(ACC_PRE, S_IDLE, 3'd0, 1'b0));
        step(); chk("wr_idle", ev(IDLE, S_IDLE, 3'd0, 1'b0));

        // request withdrawn during row phase
        set_acc(1'b1, 1'b0, 1'b1, 1'b0);
        step(); chk("ab_ras", ev(ACC_RAS, S_RAS, 3'd0, 1'b0));
        acc_req = 1'b0;
        step(); chk("ab_pre", ev(ACC_PRE, S_IDLE, 3'd0, 1'b0));
        step(); chk("ab_idle", ev(IDLE, S_IDLE, 3'd0, 1'b0));

        // idle-bus refresh ticks every 110 cycles
        run_to(109); chk("pre_tick1", ev(IDLE, S_IDLE, 3'd0, 1'b0));
        step();      chk("tick1", ev(IDLE, S_IDLE, 3'd1, 1'b0));
        do_rfsh(3'd1, 1'b0);
        run_to(219); chk("pre_tick2", ev(IDLE, S_IDLE, 3'd0, 1'b0));
        step();      chk("tick2", ev(IDLE, S_IDLE, 3'd1, 1'b0));
        do_rfsh(3'd1, 1'b0);

        // long access: pending saturates and a tick is lost
        set_acc(1'b1, 1'b0, 1'b1, 1'b1);
        step(); chk("long_ras", ev(ACC_RAS, S_RAS, 3'd0, 1'b0));
        step(); chk("long_cas", ev(ACC_CAS, cas(1'b0, 1'b0, 1'b1), 3'd0, 1'b0));
        run_to(330); chk("long_p1", ev(ACC_CAS, cas(1'b0, 1'b0, 1'b1), 3'd1, 1'b0));
        run_to(660); chk("long_p4", ev(ACC_CAS, cas(1'b0, 1'b0, 1'b1), 3'd4, 1'b0));
        run_to(769); chk("long_sat", ev(ACC_CAS, cas(1'b0, 1'b0, 1'b1), 3'd4, 1'b0));
        step();      chk("long_lost", ev(ACC_CAS, cas(1'b0, 1'b0, 1'b1), 3'd4, 1'b1));
        run_to(780); chk("long_end", ev(ACC_CAS, cas(1'b0, 1'b0, 1'b1), 3'd4, 1'b1));
        acc_req = 1'b0;
        step(); chk("long_pre", ev(ACC_PRE, S_IDLE, 3'd4, 1'b1));
        step(); chk("long_idle", ev(IDLE, S_IDLE, 3'd4, 1'b1));
        do_rfsh(3'd4, 1'b1);
        do_rfsh(3'd3, 1'b1);
        do_rfsh(3'd2, 1'b1);
        do_rfsh(3'd1, 1'b1);

        // full backlog and request together: refresh wins, access follows
        set_acc(1'b1, 1'b0, 1'b1, 1'b1);
        step();       chk("b_ras", ev(ACC_RAS, S_RAS, 3'd0, 1'b1));
        run_to(1210); chk("b_p4", ev(ACC_CAS, cas(1'b0, 1'b0, 1'b1), 3'd4, 1'b1));
        step();       chk("b_cas", ev(ACC_CAS, cas(1'b0, 1'b0, 1'b1), 3'd4, 1'b1));
        acc_req = 1'b0;
        step(); chk("b_pre", ev(ACC_PRE, S_IDLE, 3'd4, 1'b1));
        acc_req = 1'b1;
        step(); chk("b_idle", ev(IDLE, S_IDLE, 3'd4, 1'b1));
        do_rfsh(3'd4, 1'b1);
        step(); chk("b_acc_ras", ev(ACC_RAS, S_RAS, 3'd3, 1'b1));
        step(); chk("b_acc_cas", ev(ACC_CAS, cas(1'b0, 1'b0, 1'b1), 3'd3, 1'b1));
        acc_req = 1'b0;
        step(); chk("b_acc_pre", ev(ACC_PRE, S_IDLE, 3'd3, 1'b1));
        step(); chk("b_acc_idle", ev(IDLE, S_IDLE, 3'd3, 1'b1));
        step(); chk("r_cas", ev(RF_CAS, S_RCAS, 3'd3, 1'b1));
        step(); chk("r_ras", ev(RF_RAS, S_RRAS, 3'd3, 1'b1));
`ifdef RFSH_BANK_ROTATE_EN
        tests++;
        if (rfsh_bank !== 2'd3) begin
            fails++;
            $display("FAIL bank_rot got=%0d exp=3", rfsh_bank);
        end
`endif

        // reset mid-refresh, request ignored while reset is held
        rst = 1'b1;
        acc_req = 1'b1;
        step(); chk("rst_mid_rf", ev(IDLE, S_IDLE, 3'd0, 1'b0));
`ifdef RFSH_BANK_ROTATE_EN
        tests++;
        if (rfsh_bank !== 2'd0) begin
            fails++;
            $display("FAIL bank_rst got=%0d exp=0", rfsh_bank);
        end
`endif
        step(); chk("rst_hold1", ev(IDLE, S_IDLE, 3'd0, 1'b0));
        step(); chk("rst_hold2", ev(IDLE, S_IDLE, 3'd0, 1'b0));
        rst = 1'b0;
        acc_req = 1'b0;
        step(); chk("rst_rel", ev(IDLE, S_IDLE, 3'd0, 1'b0));

        // final report
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
